// File: rtl/ts_null_inserter.sv
// MPEG-TS null-packet inserter: paces a byte stream to tick_en, fills gaps with
// null packets at packet boundaries and pads short packets with 0xFF.
module ts_null_inserter #(
  parameter int unsigned PKT_LEN = 188,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_sync,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] null_count,
  output logic [CNT_W-1:0] pad_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned IDX_W = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_BOUNDARY,
    ST_PASS,
    ST_NULL
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             padded_q, padded_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sync_q, out_sync_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0] null_cnt_q, null_cnt_d;
  logic [CNT_W-1:0] pad_cnt_q, pad_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             null_inc, pad_inc, drop_inc;

  // Null packet body after the sync byte: PID 0x1FFF, payload-only, then 0xFF.
  function automatic logic [7:0] null_byte(input logic [IDX_W-1:0] i);
    logic [7:0] b;
    b = FILL_BYTE;
    if (i == IDX_W'(1)) b = 8'h1F;
    else if (i == IDX_W'(3)) b = 8'h10;
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && (c != CNT_MAX)) r = c + CNT_W'(1);
    return r;
  endfunction

  // Upstream handshake: boundary accepts anything, elsewhere only non-sync bytes.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && tick_en) begin
      case (state_q)
        ST_BOUNDARY: in_ready = in_valid;
        ST_PASS,
        ST_NULL:     in_ready = in_valid & ~in_sync;
        default:     in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    padded_d    = padded_q;
    out_valid_d = 1'b0;
    out_sync_d  = out_sync_q;
    out_data_d  = out_data_q;
    null_inc    = 1'b0;
    pad_inc     = 1'b0;
    drop_inc    = 1'b0;

    if (tick_en) begin
      out_valid_d = 1'b1;
      out_sync_d  = 1'b0;
      case (state_q)
        ST_BOUNDARY: begin
          out_sync_d = 1'b1;
          idx_d      = IDX_W'(1);
          if (in_valid && in_sync) begin
            out_data_d = in_data;
            padded_d   = 1'b0;
            state_d    = ST_PASS;
          end else begin
            out_data_d = SYNC_BYTE;
            null_inc   = 1'b1;
            drop_inc   = in_valid;
            state_d    = ST_NULL;
          end
        end
        ST_PASS, ST_NULL: begin
          if (state_q == ST_NULL) begin
            out_data_d = null_byte(idx_q);
            drop_inc   = in_valid & ~in_sync;
          end else if (in_valid && !in_sync) begin
            out_data_d = in_data;
          end else begin
            // Starved or next packet already waiting: pad, counted once per packet.
            out_data_d = FILL_BYTE;
            if (!padded_q) begin
              pad_inc  = 1'b1;
              padded_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_BOUNDARY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          idx_d   = '0;
          state_d = ST_BOUNDARY;
        end
      endcase
    end

    null_cnt_d = sat_inc(null_cnt_q, null_inc);
    pad_cnt_d  = sat_inc(pad_cnt_q, pad_inc);
    drop_cnt_d = sat_inc(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOUNDARY;
      idx_q       <= '0;
      padded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      out_data_q  <= '0;
      null_cnt_q  <= '0;
      pad_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      padded_q    <= padded_d;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      out_data_q  <= out_data_d;
      null_cnt_q  <= null_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sync   = out_sync_q;
  assign out_data   = out_data_q;
  assign null_count = null_cnt_q;
  assign pad_count  = pad_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ts_null_inserter.sv
// Scoreboard bench for ts_null_inserter: directed tick-by-tick stimulus pushes
// expected {sync,data}; a negedge monitor pops and compares each emitted byte.
module tb_ts_null_inserter;

  localparam int unsigned PKT_LEN = 188;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick_en = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sync = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic             out_valid;
  logic             out_sync;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] null_count;
  logic [CNT_W-1:0] pad_count;
  logic [CNT_W-1:0] drop_count;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  ts_null_inserter #(.PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en),
    .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sync(out_sync), .out_data(out_data),
    .null_count(null_count), .pad_count(pad_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int p, input int i);
    logic [7:0] b;
    b = (i == 0) ? 8'h47 : 8'(p * 37 + i * 3 + 1);
    return b;
  endfunction

  function automatic logic [7:0] null_exp(input int i);
    logic [7:0] b;
    case (i)
      0:       b = 8'h47;
      1:       b = 8'h1F;
      3:       b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Output monitor: every emitted byte must match the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_sync_data", int'({out_sync, out_data}), int'(e));
      end
    end
  end

  task automatic do_tick(input logic v, input logic s, input logic [7:0] d,
                         input logic er, input logic es, input logic [7:0] ed);
    @(negedge clk);
    tick_en = 1'b1; in_valid = v; in_sync = s; in_data = d;
    #1;
    check("in_ready", int'(in_ready), int'(er));
    exp_q.push_back({es, ed});
    @(negedge clk);
    tick_en = 1'b0;
    #1;
    check("in_ready_no_tick", int'(in_ready), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick_en = 1'b1; in_valid = 1'b1; in_sync = 1'b1; in_data = 8'h47;
    #1;
    check("in_ready_in_reset", int'(in_ready), 0);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sync", int'(out_sync), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_null_count", int'(null_count), 0);
    check("rst_pad_count", int'(pad_count), 0);
    check("rst_drop_count", int'(drop_count), 0);
    tick_en = 1'b0; in_valid = 1'b0; in_sync = 1'b0; rst = 1'b0;
  endtask

  task automatic send_pkt(input int p);
    for (int i = 0; i < int'(PKT_LEN); i++)
      do_tick(1'b1, i == 0, pkt_byte(p, i), 1'b1, i == 0, pkt_byte(p, i));
  endtask

  task automatic check_counts(input string tag, input int n, input int p, input int d);
    check({tag, "_null_count"}, int'(null_count), n);
    check({tag, "_pad_count"}, int'(pad_count), p);
    check({tag, "_drop_count"}, int'(drop_count), d);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Back-to-back well-formed packets pass through untouched.
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(p);
    check_counts("passthru", 0, 0, 0);

    // Idle input: null packets back to back, third one started.
    do_reset();
    for (int t = 0; t < 400; t++)
      do_tick(1'b0, 1'b0, 8'h00, 1'b0, (t % int'(PKT_LEN)) == 0, null_exp(t % int'(PKT_LEN)));
    check_counts("idle", 3, 0, 0);

    // Stall from idx 100 to the end: padded tail, next packet passed.
    do_reset();
    for (int i = 0; i < 100; i++)
      do_tick(1'b1, i == 0, pkt_byte(3, i), 1'b1, i == 0, pkt_byte(3, i));
    for (int i = 100; i < int'(PKT_LEN); i++)
      do_tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
    send_pkt(4);
    check_counts("stall", 0, 1, 0);

    // Stray bytes while idle: one null packet, sync packet waits, then intact.
    do_reset();
    do_tick(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 8'h47);
    do_tick(1'b1, 1'b0, 8'hBB, 1'b1, 1'b0, 8'h1F);
    do_tick(1'b1, 1'b0, 8'hCC, 1'b1, 1'b0, 8'hFF);
    for (int i = 3; i < int'(PKT_LEN); i++)
      do_tick(1'b1, 1'b1, 8'h47, 1'b0, 1'b0, null_exp(i));
    send_pkt(6);
    check_counts("stray", 1, 0, 3);

    // Reset at idx 50 of a passed packet clears counters; next tick is a boundary.
    for (int i = 0; i < 50; i++)
      do_tick(1'b1, i == 0, pkt_byte(7, i), 1'b1, i == 0, pkt_byte(7, i));
    do_reset();
    do_tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h47);
    check_counts("after_rst", 1, 0, 0);

    // Saturation of the 4-bit null counter over 20 null packets.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < int'(PKT_LEN); i++)
        do_tick(1'b0, 1'b0, 8'h00, 1'b0, i == 0, null_exp(i));
      if (k == 14) check("null_count_at_15", int'(null_count), 15);
    end
    check_counts("saturate", 15, 0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ts_null_inserter.md
TS_NULL_INSERTER -- requirements
Module: ts_null_inserter

Interface
REQ-001 Parameter PKT_LEN, default 188, TS packet length in bytes (minimum 5).
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick_en  input  1  one-cycle output byte strobe (27 MHz pulse in the 108 MHz clk domain).
REQ-006 in_valid  input  1  upstream byte available.
REQ-007 in_sync  input  1  upstream byte is the first byte (0x47) of a packet.
REQ-008 in_data  input  8  upstream byte.
REQ-009 in_ready  output  1  combinational; the byte is consumed in a cycle where in_valid=1 and in_ready=1.
REQ-010 out_valid  output  1  registered; one-cycle pulse per emitted byte.
REQ-011 out_sync  output  1  registered; high with the first byte of each output packet.
REQ-012 out_data  output  8  registered output byte.
REQ-013 null_count  output  CNT_W  number of null packets started; saturating.
REQ-014 pad_count  output  CNT_W  number of passed packets that needed padding; saturating.
REQ-015 drop_count  output  CNT_W  number of discarded non-sync bytes; saturating.

Function
REQ-016 The block SHALL emit exactly one byte per tick_en pulse, with out_valid, out_sync and out_data updated on the clk edge that samples tick_en=1 (latency 1 clk).
REQ-017 When tick_en=0, in_ready SHALL be 0 and out_valid SHALL be 0. All state SHALL hold.
REQ-018 State SHALL be one of BOUNDARY, PASS or NULL, tracked with a byte counter idx ranging 0..PKT_LEN-1.
REQ-019 BOUNDARY with tick_en=1 and in_valid=1 and in_sync=1: consume the byte, emit it with out_sync=1, set idx=1, and go to PASS.
REQ-020 BOUNDARY with tick_en=1 in any other case: emit 0x47 with out_sync=1, set idx=1, go to NULL, and increment null_count.
REQ-021 In BOUNDARY, if in_valid=1 and in_sync=0, the byte SHALL also be consumed in the same cycle and drop_count SHALL be incremented.
REQ-022 NULL packet bytes SHALL be: idx1=0x1F, idx2=0xFF, idx3=0x10, and idx4..PKT_LEN-1=0xFF.
REQ-023 In NULL with tick_en=1: in_ready = in_valid & ~in_sync, so stray bytes are flushed; each flushed byte increments drop_count. Sync bytes SHALL NOT be consumed.
REQ-024 PASS with tick_en=1 and in_valid=1 and in_sync=0: consume the byte and emit in_data.
REQ-025 PASS with tick_en=1 and (in_valid=0 or in_sync=1): do not consume; emit 0xFF. On the first such event in the packet, increment pad_count (at most once per packet).
REQ-026 PASS or NULL with tick_en=1 at idx=PKT_LEN-1: emit the final byte and go to BOUNDARY with idx=0. Otherwise increment idx.
REQ-027 out_sync SHALL be 0 for every byte with idx not equal to 0.
REQ-028 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 When a counter increment and a saturation coincide, the counter SHALL hold at its maximum value.

Reset
REQ-030 rst=1 at the sampled edge SHALL set state=BOUNDARY, idx=0, out_valid=0, out_sync=0, out_data=0x00, and clear all counters to 0.
REQ-031 rst SHALL override tick_en; in_ready SHALL be 0 while rst=1.
REQ-032 Reset mid-packet SHALL abandon the packet; the next tick after release starts at BOUNDARY.

Verification
REQ-033 Continuous well-formed 188-byte packets, one byte per tick -> output is bit-identical to the input, null_count=0, pad_count=0, drop_count=0.
REQ-034 in_valid=0 for 400 ticks after reset -> two complete null packets (47 1F FF 10 FF...) and the start of a third; null_count=3; out_sync high exactly at ticks 0, 188 and 376.
REQ-035 Packet that stalls (in_valid=0) from idx 100 to idx 187 -> bytes 100..187 output as 0xFF, pad_count=1, then the next ready sync packet is passed at the following boundary.
REQ-036 Three stray non-sync bytes presented while idle, then a sync packet -> drop_count=3, one null packet emitted, and the sync packet emitted intact afterwards.
REQ-037 rst asserted at idx 50 of PASS -> outputs and counters zero next cycle; the first tick after release is a boundary decision.
REQ-038 Counters preloaded near saturation (CNT_W=4, 20 null packets) -> null_count sticks at 15.
